// File: rtl/pipelined_adder_sub.sv
// N-bit adder/subtractor split into STAGES carry-ripple slices with a valid/ready handshake.
// Define OVF_DETECT_EN to add a registered signed-overflow output.
module pipelined_adder_sub #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry_out
`ifdef OVF_DETECT_EN
    ,
    output logic         overflow
`endif
);
    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder_sub: STAGES must be in 1..N and divide N");
    end

    logic         adv_s;
    logic [N-1:0] b_eff_s;
    logic         cin_eff_s;

    // Global advance enable plus operand conditioning for subtraction.
    always_comb begin
        adv_s    = !out_valid || out_ready;
        in_ready = adv_s;
        if (sub) begin
            b_eff_s   = ~b;
            cin_eff_s = ~carry_in;
        end else begin
            b_eff_s   = b;
            cin_eff_s = carry_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operands entering slice k hold only the chunks not yet summed, current chunk at the LSBs.
        localparam int REM = N - k * W;

        logic [REM-1:0]       a_cur_s;
        logic [REM-1:0]       b_cur_s;
        logic                 c_cur_s;
        logic                 v_cur_s;
        logic [W-1:0]         chunk_s;
        logic                 c_out_s;
        logic [(k+1)*W-1:0]   sum_d;
        logic [(k+1)*W-1:0]   sum_q;
        logic                 vld_q;
        logic                 cy_q;

        if (k == 0) begin : g_head
            assign a_cur_s = a;
            assign b_cur_s = b_eff_s;
            assign c_cur_s = cin_eff_s;
            assign v_cur_s = in_valid;
            assign sum_d   = chunk_s;
        end else begin : g_body
            assign a_cur_s = g_stage[k-1].g_fwd.a_q;
            assign b_cur_s = g_stage[k-1].g_fwd.b_q;
            assign c_cur_s = g_stage[k-1].cy_q;
            assign v_cur_s = g_stage[k-1].vld_q;
            assign sum_d   = {chunk_s, g_stage[k-1].sum_q};
        end

        // W-bit ripple slice for this stage's chunk.
        always_comb begin
            {c_out_s, chunk_s} = {1'b0, a_cur_s[W-1:0]} + {1'b0, b_cur_s[W-1:0]}
                               + {{W{1'b0}}, c_cur_s};
        end

        // Stage rank: valid, slice carry and the growing sum move together under the global stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv_s) begin
                vld_q <= v_cur_s;
                cy_q  <= c_out_s;
                sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-W-1:0] a_q;
            logic [REM-W-1:0] b_q;

            // Upper operand chunks ride along to the slices that still need them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv_s) begin
                    a_q <= a_cur_s[REM-1:W];
                    b_q <= b_cur_s[REM-1:W];
                end
            end
        end

`ifdef OVF_DETECT_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            // The top chunk carries the operand sign bits, so overflow is resolved in the last slice.
            always_comb begin
                ovf_d = (a_cur_s[W-1] == b_cur_s[W-1]) && (chunk_s[W-1] != a_cur_s[W-1]);
            end

            // Overflow flag registered alongside the final sum chunk.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv_s) begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign carry_out = g_stage[STAGES-1].cy_q;
`ifdef OVF_DETECT_EN
    assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Directed bench for pipelined_adder_sub: main instance STAGES=2, plus STAGES 1/4/8 for the sweep.
module tb_pipelined_adder_sub;
    localparam int N  = 8;
    localparam int NI = 4;

    function automatic int st_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry_in;
    logic         sub_op;
    logic         out_ready;

    logic         in_ready_w  [NI];
    logic         out_valid_w [NI];
    logic [N-1:0] sum_w       [NI];
    logic         co_w        [NI];
`ifdef OVF_DETECT_EN
    logic         ovf_w       [NI];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        pipelined_adder_sub #(.N(N), .STAGES(st_of(i))) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[i]),
            .a         (a),
            .b         (b),
            .carry_in  (carry_in),
            .sub       (sub_op),
            .out_valid (out_valid_w[i]),
            .out_ready (out_ready),
            .sum       (sum_w[i]),
            .carry_out (co_w[i])
`ifdef OVF_DETECT_EN
            ,
            .overflow  (ovf_w[i])
`endif
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] xa, input logic [7:0] xb, input logic ci, input logic s);
        a        = xa;
        b        = xb;
        carry_in = ci;
        sub_op   = s;
        in_valid = 1'b1;
    endtask

    function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                             input logic ci, input logic s);
        logic [7:0] yp;
        logic       cc;
        logic [8:0] r;
        logic       ov;
        yp = s ? ~y : y;
        cc = s ? ~ci : ci;
        r  = {1'b0, x} + {1'b0, yp} + {8'h00, cc};
        ov = (x[7] == yp[7]) && (r[7] != x[7]);
        return {ov, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00;
        carry_in = 1'b0; sub_op = 1'b0; out_ready = 1'b0;
        #3;
        total++; if (out_valid_w[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_w[0]); end
        total++; if (sum_w[0] !== 8'h00) begin bad++; $display("FAIL reset_sum: got %h want 00", sum_w[0]); end
        total++; if (co_w[0] !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b want 0", co_w[0]); end
        total++; if (in_ready_w[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_w[0]); end
`ifdef OVF_DETECT_EN
        total++; if (ovf_w[0] !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", ovf_w[0]); end
`endif
        tick(); tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        total++; if (out_valid_w[0] !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", out_valid_w[0]); end
    endtask

    task automatic test_add();
        drive(8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        drive(8'h3C, 8'h0F, 1'b1, 1'b0);
        total++; if (out_valid_w[0] !== 1'b0) begin bad++; $display("FAIL add_latency: got valid %b want 0", out_valid_w[0]); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid_w[0] !== 1'b1) begin bad++; $display("FAIL add_wrap_valid: got %b want 1", out_valid_w[0]); end
        total++; if (sum_w[0] !== 8'h00) begin bad++; $display("FAIL add_wrap_sum: got %h want 00", sum_w[0]); end
        total++; if (co_w[0] !== 1'b1) begin bad++; $display("FAIL add_wrap_carry: got %b want 1", co_w[0]); end
        tick();
        total++; if (sum_w[0] !== 8'h4C || co_w[0] !== 1'b0) begin bad++; $display("FAIL add_cin: got %b/%h want 0/4c", co_w[0], sum_w[0]); end
        tick();
        total++; if (out_valid_w[0] !== 1'b0) begin bad++; $display("FAIL add_bubble: got valid %b want 0", out_valid_w[0]); end
    endtask

    task automatic test_sub();
        drive(8'h05, 8'h07, 1'b0, 1'b1);
        tick();
        drive(8'h07, 8'h05, 1'b0, 1'b1);
        tick();
        drive(8'h07, 8'h05, 1'b1, 1'b1);
        total++; if (out_valid_w[0] !== 1'b1 || sum_w[0] !== 8'hFE || co_w[0] !== 1'b0) begin
            bad++; $display("FAIL sub_borrow: got v%b co%b %h want v1 co0 fe", out_valid_w[0], co_w[0], sum_w[0]); end
        tick();
        in_valid = 1'b0; sub_op = 1'b0;
        total++; if (out_valid_w[0] !== 1'b1 || sum_w[0] !== 8'h02 || co_w[0] !== 1'b1) begin
            bad++; $display("FAIL sub_pos: got v%b co%b %h want v1 co1 02", out_valid_w[0], co_w[0], sum_w[0]); end
        tick();
        total++; if (out_valid_w[0] !== 1'b1 || sum_w[0] !== 8'h01 || co_w[0] !== 1'b1) begin
            bad++; $display("FAIL sub_borrow_in: got v%b co%b %h want v1 co1 01", out_valid_w[0], co_w[0], sum_w[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        int sent   = 0;
        int nrecv  = 0;
        int stalls = 0;
        for (int c = 0; c < 30 && nrecv < 4; c++) begin
            out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            a = 8'(sent + 1); b = 8'(sent + 1); carry_in = 1'b0; sub_op = 1'b0;
            in_valid = (sent < 4);
            #1;
            if (out_valid_w[0] && !out_ready) begin
                stalls++;
                total++; if (in_ready_w[0] !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready_w[0]); end
                total++; if (sum_w[0] !== 8'((nrecv + 1) * 2)) begin bad++; $display("FAIL stall_hold: got %h want %h", sum_w[0], 8'((nrecv + 1) * 2)); end
            end
            if (out_valid_w[0] && out_ready) begin
                total++; if (sum_w[0] !== 8'((nrecv + 1) * 2)) begin bad++; $display("FAIL b2b_order: got %h want %h", sum_w[0], 8'((nrecv + 1) * 2)); end
                nrecv++;
            end
            if (in_valid && in_ready_w[0]) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (nrecv !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", nrecv); end
        total++; if (stalls !== 3) begin bad++; $display("FAIL b2b_stalls: got %0d want 3", stalls); end
        tick(); tick();
    endtask

`ifdef OVF_DETECT_EN
    task automatic test_overflow();
        drive(8'h7F, 8'h01, 1'b0, 1'b0);
        tick();
        drive(8'h80, 8'h01, 1'b0, 1'b1);
        tick();
        drive(8'h10, 8'h20, 1'b0, 1'b0);
        total++; if (sum_w[0] !== 8'h80 || ovf_w[0] !== 1'b1) begin bad++; $display("FAIL ovf_pos: got %h/%b want 80/1", sum_w[0], ovf_w[0]); end
        tick();
        in_valid = 1'b0;
        total++; if (sum_w[0] !== 8'h7F || ovf_w[0] !== 1'b1) begin bad++; $display("FAIL ovf_neg: got %h/%b want 7f/1", sum_w[0], ovf_w[0]); end
        tick();
        total++; if (sum_w[0] !== 8'h30 || ovf_w[0] !== 1'b0) begin bad++; $display("FAIL ovf_none: got %h/%b want 30/0", sum_w[0], ovf_w[0]); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        logic anyv;
        drive(8'h11, 8'h22, 1'b0, 1'b0);
        tick();
        drive(8'h33, 8'h44, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #2;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            anyv = out_valid_w[0] | out_valid_w[1] | out_valid_w[2] | out_valid_w[3];
            total++; if (anyv !== 1'b0) begin bad++; $display("FAIL reset_mid_valid: got %b want 0 at cycle %0d", anyv, c); end
            tick();
        end
    endtask

    task automatic test_sweep();
        localparam int K = 16;
        logic [7:0] ra [K];
        logic [7:0] rb [K];
        logic       rc [K];
        logic       rs [K];
        logic [9:0] ex [K];
        for (int j = 0; j < K; j++) begin
            ra[j] = 8'($urandom); rb[j] = 8'($urandom);
            rc[j] = 1'($urandom); rs[j] = 1'($urandom);
            ex[j] = ref_model(ra[j], rb[j], rc[j], rs[j]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < K + 10; c++) begin
            for (int i = 0; i < NI; i++) begin
                int j;
                j = c - st_of(i);
                if (j >= 0 && j < K) begin
                    total++;
                    if ({out_valid_w[i], co_w[i], sum_w[i]} !== {1'b1, ex[j][8:0]}) begin
                        bad++; $display("FAIL sweep_s%0d_beat%0d: got v%b %b_%h want v1 %b_%h",
                                        st_of(i), j, out_valid_w[i], co_w[i], sum_w[i], ex[j][8], ex[j][7:0]);
                    end
`ifdef OVF_DETECT_EN
                    total++;
                    if (ovf_w[i] !== ex[j][9]) begin
                        bad++; $display("FAIL sweep_ovf_s%0d_beat%0d: got %b want %b", st_of(i), j, ovf_w[i], ex[j][9]);
                    end
`endif
                end else begin
                    total++;
                    if (out_valid_w[i] !== 1'b0) begin
                        bad++; $display("FAIL sweep_idle_s%0d: got valid %b want 0 at cycle %0d", st_of(i), out_valid_w[i], c);
                    end
                end
            end
            if (c < K) drive(ra[c], rb[c], rc[c], rs[c]);
            else in_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
`ifdef OVF_DETECT_EN
        test_overflow();
`endif
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
